regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters.
- Requester A is the ALU writeback path. Requester B is the load/memory writeback path.
- Fixed priority favours B. A starvation guard bounds how long A can be denied.
- The granted write is registered and presented to the register file write port one cycle after acceptance.

---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file write port.
// The arbiter uses the slave modport. Requesters and the register-file side use master.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the ALU writeback (A) and the
// load writeback (B). B has fixed priority. A starvation counter forces A to win once
// it has been denied STARVE_MAX consecutive cycles. The granted write is registered
// and reaches the register file one cycle after acceptance. Writes to x0 are
// consumed but never raise rf_we.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  wb,
    output logic [3:0]           starve_cnt,
    output logic [CNT_W-1:0]     contention_cnt
);
    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] ZERO_ADDR  = '0;
    localparam logic [CNT_W-1:0]  CNT_SAT    = '1;

    logic              grant_a;
    logic              grant_b;
    logic              both_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign both_valid = wb.a_valid && wb.b_valid;

    // Pick at most one winner per cycle and steer its address/data toward the output register.
    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        sel_addr = wb.b_addr;
        sel_data = wb.b_data;
        if (!rst) begin
            if (both_valid) begin
                if (starve_cnt == STARVE_LIM) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (wb.a_valid) begin
                grant_a = 1'b1;
            end else if (wb.b_valid) begin
                grant_b = 1'b1;
            end
        end
        if (grant_a) begin
            sel_addr = wb.a_addr;
            sel_data = wb.a_data;
        end
    end

    assign wb.a_ready = grant_a;
    assign wb.b_ready = grant_b;

    // Output stage: register the granted write. rf_we stays low for x0 and for idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb.rf_we    <= 1'b0;
            wb.rf_waddr <= '0;
            wb.rf_wdata <= '0;
        end else if (grant_a || grant_b) begin
            wb.rf_we    <= (sel_addr != ZERO_ADDR);
            wb.rf_waddr <= sel_addr;
            wb.rf_wdata <= sel_data;
        end else begin
            wb.rf_we    <= 1'b0;
        end
    end

    // Count consecutive cycles A waited while valid. Any grant or idle cycle for A clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (wb.a_valid && !grant_a) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    // Saturating count of cycles in which both requesters competed for the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            contention_cnt <= '0;
        end else if (both_valid && (contention_cnt != CNT_SAT)) begin
            contention_cnt <= contention_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by a
// randomized run compared against a cycle-level behavioural model of the arbiter.
module tb_regfile_wb_arbiter;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 3;
    // A narrow contention counter so that saturation is reachable in a short run.
    localparam int TB_CNT_W   = 4;
    localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

    logic                clk;
    logic                rst;
    logic [3:0]          starve_cnt;
    logic [TB_CNT_W-1:0] contention_cnt;

    int checks;
    int failures;

    // Behavioural model state
    int                m_starve;
    int                m_cont;
    logic              m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .CNT_W(TB_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb(bus),
        .starve_cnt(starve_cnt),
        .contention_cnt(contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all inputs just after a falling edge, then let combinational ready settle.
    task automatic applyStimulus(input logic r, input logic av, input logic [ADDR_W-1:0] aa,
                                 input logic [DATA_W-1:0] ad, input logic bv,
                                 input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        rst         = r;
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
        #1;
    endtask

    // Advance through one rising edge and stop on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
            checks++;
            if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_ready: a_ready=%b b_ready=%b expected 0/0", bus.a_ready, bus.b_ready);
            end
            tick();
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: we=%b waddr=%0d wdata=%h expected 0/0/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        checks++;
        if (starve_cnt !== 4'd0 || contention_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL reset_counters: starve=%0d contention=%0d expected 0/0", starve_cnt, contention_cnt);
        end
    endtask

    task automatic test_single_writer();
        applyStimulus(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_ready: a_ready=%b b_ready=%b expected 1/0", bus.a_ready, bus.b_ready);
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL single_write: we=%b waddr=%0d wdata=%h expected 1/5/12345678", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        applyStimulus(1'b0, 1'b0, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL single_idle: we=%b waddr=%0d wdata=%h expected 0/5/12345678", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
    endtask

    task automatic test_priority();
        applyStimulus(1'b0, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB);
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL prio_ready: a_ready=%b b_ready=%b expected 0/1", bus.a_ready, bus.b_ready);
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'hBBBB) begin
            failures++;
            $display("[TB] FAIL prio_b_write: we=%b waddr=%0d wdata=%h expected 1/4/bbbb", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        checks++;
        if (starve_cnt !== 4'd1 || contention_cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL prio_counters: starve=%0d contention=%0d expected 1/1", starve_cnt, contention_cnt);
        end
        applyStimulus(1'b0, 1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd4, 32'hBBBB);
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prio_a_ready: a_ready=%b b_ready=%b expected 1/0", bus.a_ready, bus.b_ready);
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'hAAAA || starve_cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL prio_a_write: we=%b waddr=%0d wdata=%h starve=%0d expected 1/3/aaaa/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, starve_cnt);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_starvation();
        logic [DATA_W-1:0] adata;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        bit                a_turn;
        adata = 32'h900;
        for (int k = 0; k < 8; k++) begin
            a_turn = ((k % 4) == 3);
            applyStimulus(1'b0, 1'b1, 5'd9, adata, 1'b1, 5'(10 + k), 32'(k + 1));
            checks++;
            if (bus.a_ready !== a_turn || bus.b_ready !== !a_turn || starve_cnt !== 4'(k % 4)) begin
                failures++;
                $display("[TB] FAIL starve_grant k=%0d: a_ready=%b b_ready=%b starve=%0d expected %b/%b/%0d",
                         k, bus.a_ready, bus.b_ready, starve_cnt, a_turn, !a_turn, k % 4);
            end
            exp_addr = a_turn ? 5'd9 : 5'(10 + k);
            exp_data = a_turn ? adata : 32'(k + 1);
            tick();
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_waddr !== exp_addr || bus.rf_wdata !== exp_data) begin
                failures++;
                $display("[TB] FAIL starve_write k=%0d: we=%b waddr=%0d wdata=%h expected 1/%0d/%h",
                         k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_addr, exp_data);
            end
            if (a_turn) adata = adata + 32'h1;
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_x0_discard();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        checks++;
        if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_ready: a_ready=%b b_ready=%b expected 0/1", bus.a_ready, bus.b_ready);
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL x0_write: we=%b waddr=%0d wdata=%h expected 0/0/ffffffff", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.a_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_ready: a_ready=%b expected 0", bus.a_ready);
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b0 || contention_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL rstmid_discard: we=%b contention=%0d expected 0/0", bus.rf_we, contention_cnt);
        end
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.a_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_regrant: a_ready=%b expected 1", bus.a_ready);
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h77) begin
            failures++;
            $display("[TB] FAIL rstmid_write: we=%b waddr=%0d wdata=%h expected 1/7/77", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_contention_saturation();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd1, 32'(i), 1'b1, 5'd2, 32'(i));
            tick();
            checks++;
            if (contention_cnt !== TB_CNT_W'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1)) begin
                failures++;
                $display("[TB] FAIL contention_sat i=%0d: contention=%0d expected %0d",
                         i, contention_cnt, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
            end
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_random();
        bit                pa, pb, r, ea, eb;
        logic [ADDR_W-1:0] aa, ba;
        logic [DATA_W-1:0] ad, bd;
        pa = 0; pb = 0; aa = '0; ba = '0; ad = '0; bd = '0;
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        m_starve = 0; m_cont = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && $urandom_range(0, 99) < 70) begin
                pa = 1;
                aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                ad = $urandom;
            end
            if (!pb && $urandom_range(0, 99) < 75) begin
                pb = 1;
                ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                bd = $urandom;
            end
            r = ($urandom_range(0, 63) == 0);
            applyStimulus(r, pa, aa, ad, pb, ba, bd);
            // Reference: B wins unless A has already waited STARVE_MAX cycles.
            ea = !r && pa && (!pb || m_starve >= STARVE_MAX);
            eb = !r && pb && !ea;
            checks++;
            if (bus.a_ready !== ea || bus.b_ready !== eb) begin
                failures++;
                $display("[TB] FAIL rand_ready c=%0d: a_ready=%b b_ready=%b expected %b/%b", c, bus.a_ready, bus.b_ready, ea, eb);
            end
            if (r) begin
                m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_starve = 0; m_cont = 0;
            end else begin
                if (ea) begin
                    m_we = (aa != 0); m_waddr = aa; m_wdata = ad;
                end else if (eb) begin
                    m_we = (ba != 0); m_waddr = ba; m_wdata = bd;
                end else begin
                    m_we = 1'b0;
                end
                m_starve = (pa && !ea) ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
                if (pa && pb && m_cont < CNT_MAX) m_cont = m_cont + 1;
            end
            if (ea) pa = 0;
            if (eb) pb = 0;
            tick();
            checks++;
            if (bus.rf_we !== m_we || bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata) begin
                failures++;
                $display("[TB] FAIL rand_write c=%0d: we=%b waddr=%0d wdata=%h expected %b/%0d/%h",
                         c, bus.rf_we, bus.rf_waddr, bus.rf_wdata, m_we, m_waddr, m_wdata);
            end
            checks++;
            if (starve_cnt !== 4'(m_starve) || contention_cnt !== TB_CNT_W'(m_cont)) begin
                failures++;
                $display("[TB] FAIL rand_counters c=%0d: starve=%0d contention=%0d expected %0d/%0d",
                         c, starve_cnt, contention_cnt, m_starve, m_cont);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        @(negedge clk);
        test_reset();
        test_single_writer();
        test_priority();
        test_starvation();
        test_x0_discard();
        test_reset_mid();
        test_contention_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
